// File: rtl/pwm_reader_block.sv
// RC receiver PWM high-time reader with validation and signal-loss detection.
// Optional PWM_READER_AVG_EN: accepted values averaged with the previous one.
module pwm_reader_block #(
  parameter int VALUE_WIDTH = 10,
  parameter int MIN_HIGH_US = 1000,
  parameter int MAX_HIGH_US = 2000,
  parameter int TOL_US      = 100,
  parameter int TIMEOUT_US  = 25000
) (
  input  logic                   us_clk,
  input  logic                   resetn,
  input  logic                   pwm_in,
  output logic [VALUE_WIDTH-1:0] value,
  output logic                   value_valid,
  output logic                   error_strobe,
  output logic                   signal_lost,
  output logic [2:0]             state_out
);

  localparam logic [15:0] LO_LIM = 16'(MIN_HIGH_US - TOL_US);
  localparam logic [15:0] HI_LIM = 16'(MAX_HIGH_US + TOL_US);
  localparam logic [15:0] MIN_W  = 16'(MIN_HIGH_US);
  localparam logic [15:0] MAX_W  = 16'(MAX_HIGH_US);
  localparam logic [15:0] TMO    = 16'(TIMEOUT_US);
  localparam logic [VALUE_WIDTH-1:0] SPAN =
    VALUE_WIDTH'(MAX_HIGH_US - MIN_HIGH_US);

  typedef enum logic [2:0] {
    STATE_WAIT_LOW  = 3'b001,
    STATE_WAIT_HIGH = 3'b010,
    STATE_MEASURE   = 3'b100
  } state_t;

  // [0] metastable stage, [1] pwm_s, [2] pwm_s delayed.
  // Reset to all-ones so a pulse in flight at reset release
  // never looks like a rising edge.
  logic [2:0] sync_q, sync_d;
  state_t     state_q, state_d;
  logic [15:0] high_cnt_q, high_cnt_d;
  logic [15:0] period_cnt_q, period_cnt_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic lost_q, lost_d;

  logic pwm_s, pwm_s_dly, rise;
  logic [VALUE_WIDTH-1:0] clamped;
  logic [VALUE_WIDTH-1:0] new_value;

  // Shift the raw input through the synchronizer and edge delay.
  always_comb begin
    sync_d = {sync_q[1:0], pwm_in};
  end

  assign pwm_s     = sync_q[1];
  assign pwm_s_dly = sync_q[2];
  assign rise      = pwm_s & ~pwm_s_dly;

  // Map the measured width onto the output range with clamping.
  always_comb begin
    if (high_cnt_q <= MIN_W) begin
      clamped = '0;
    end else if (high_cnt_q >= MAX_W) begin
      clamped = SPAN;
    end else begin
      clamped = VALUE_WIDTH'(high_cnt_q - MIN_W);
    end
  end

`ifdef PWM_READER_AVG_EN
  logic [VALUE_WIDTH-1:0] prev_q, prev_d;
  logic [VALUE_WIDTH:0]   sum;

  // Average with the previous sample, except right after loss/reset.
  always_comb begin
    sum       = {1'b0, clamped} + {1'b0, prev_q};
    new_value = lost_q ? clamped : sum[VALUE_WIDTH:1];
    prev_d    = valid_d ? clamped : prev_q;
  end

  // Hold the last accepted unfiltered sample.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  // Report the clamped sample directly.
  always_comb begin
    new_value = clamped;
  end
`endif

  // Next-state logic: measurement FSM, counters and outputs.
  always_comb begin
    state_d      = state_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    value_d      = value_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    lost_d       = lost_q;

    if (rise) begin
      period_cnt_d = 16'd1;
    end else if (period_cnt_q != 16'hFFFF) begin
      period_cnt_d = period_cnt_q + 16'd1;
    end

    unique case (state_q)
      STATE_WAIT_LOW: begin
        if (!pwm_s) begin
          state_d = STATE_WAIT_HIGH;
        end
      end
      STATE_WAIT_HIGH: begin
        if (rise) begin
          state_d    = STATE_MEASURE;
          high_cnt_d = 16'd1;
        end
      end
      STATE_MEASURE: begin
        if (pwm_s) begin
          if (high_cnt_q == HI_LIM) begin
            err_d   = 1'b1;
            state_d = STATE_WAIT_LOW;
          end else if (high_cnt_q != 16'hFFFF) begin
            high_cnt_d = high_cnt_q + 16'd1;
          end
        end else begin
          state_d = STATE_WAIT_HIGH;
          if (high_cnt_q < LO_LIM) begin
            err_d = 1'b1;
          end else begin
            value_d = new_value;
            valid_d = 1'b1;
            lost_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = STATE_WAIT_LOW;
      end
    endcase

    if (period_cnt_q == TMO) begin
      lost_d  = 1'b1;
      value_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      sync_q       <= 3'b111;
      state_q      <= STATE_WAIT_LOW;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      value_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      lost_q       <= 1'b1;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      lost_q       <= lost_d;
    end
  end

  assign value        = value_q;
  assign value_valid  = valid_q;
  assign error_strobe = err_q;
  assign signal_lost  = lost_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_pwm_reader_block.sv
// Bench for pwm_reader_block: table vectors, random pulse trains
// checked against a pulse-level model, plus timeout and reset cases.
`timescale 1ns/1ps
module tb_pwm_reader_block;

  localparam int VW  = 10;
  localparam int TMO = 25000;
  localparam int NT  = 14;

  typedef struct {
    int width;
    bit exp_valid;
    bit exp_err;
    int exp_clamp;
  } vec_t;

  vec_t tbl[NT];

  logic          us_clk = 1'b0;
  logic          resetn = 1'b0;
  logic          pwm_in = 1'b0;
  logic [VW-1:0] value;
  logic          value_valid;
  logic          error_strobe;
  logic          signal_lost;
  logic [2:0]    state_out;

  pwm_reader_block dut (
    .us_clk      (us_clk),
    .resetn      (resetn),
    .pwm_in      (pwm_in),
    .value       (value),
    .value_valid (value_valid),
    .error_strobe(error_strobe),
    .signal_lost (signal_lost),
    .state_out   (state_out)
  );

  always #5 us_clk = ~us_clk;

  int checks = 0;
  int errors = 0;

  bit stim[$];
  int acc_w[int];
  bit err_at[int];
  bit lost_at[int];

  int got_kind[$];
  int got_val[$];
  int lost_edge;
  int n_valid;
  int exp_val;
  bit exp_lost;
  int prev_c;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
      if (errors >= 40) begin
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
      end
    end
  endtask

  function automatic int clamp_w(input int w);
    int c;
    c = w - 1000;
    if (c < 0) c = 0;
    if (c > 1000) c = 1000;
    return c;
  endfunction

  task automatic add(input bit lvl, input int n);
    repeat (n) stim.push_back(lvl);
  endtask

  // Pulse-level model: every run of highs preceded by a low is one
  // pulse; its length decides the outcome and when it is reported.
  function automatic void build_model();
    int rises[$];
    int n;
    n = stim.size();
    acc_w.delete();
    err_at.delete();
    lost_at.delete();
    rises.push_back(1);
    for (int t = 0; t < n; t++) begin
      bit prv;
      prv = (t == 0) ? 1'b1 : stim[t-1];
      if (stim[t] && !prv) begin
        int w;
        w = 0;
        while (t + w < n && stim[t+w]) w++;
        rises.push_back(t + 3);
        if (w > 2100) err_at[t + 2103] = 1'b1;
        else if (t + w < n) begin
          if (w < 900) err_at[t + w + 3] = 1'b1;
          else acc_w[t + w + 3] = w;
        end
      end
    end
    for (int i = 0; i < rises.size(); i++) begin
      int nxt;
      nxt = (i + 1 < rises.size()) ? rises[i+1] : 32'h7fffffff;
      if (nxt > rises[i] + TMO) lost_at[rises[i] + TMO] = 1'b1;
    end
  endfunction

  task automatic run_scenario();
    bit last_lost;
    build_model();
    exp_val  = 0;
    exp_lost = 1'b1;
    prev_c   = 0;
    got_kind.delete();
    got_val.delete();
    lost_edge = -1;
    n_valid   = 0;
    last_lost = 1'b1;
    @(posedge us_clk);
    #1;
    resetn = 1'b0;
    pwm_in = stim[0];
    #2;
    chk("reset_state",
        {value, value_valid, error_strobe, signal_lost, state_out},
        {10'd0, 1'b0, 1'b0, 1'b1, 3'b001});
    @(posedge us_clk);
    #1;
    resetn = 1'b1;
    for (int e = 1; e <= stim.size(); e++) begin
      bit ev;
      bit ee;
      int c;
      @(posedge us_clk);
      #1;
      ev = acc_w.exists(e);
      ee = err_at.exists(e);
      if (ev) begin
        c = clamp_w(acc_w[e]);
`ifdef PWM_READER_AVG_EN
        exp_val = exp_lost ? c : (c + prev_c) / 2;
`else
        exp_val = c;
`endif
        prev_c   = c;
        exp_lost = 1'b0;
      end
      if (lost_at.exists(e)) begin
        exp_lost = 1'b1;
        exp_val  = 0;
      end
      chk($sformatf("cycle%0d", e),
          {value, value_valid, error_strobe, signal_lost,
           $onehot(state_out)},
          {10'(exp_val), ev, ee, exp_lost, 1'b1});
      if (value_valid) begin
        got_kind.push_back(1);
        got_val.push_back(int'(value));
        n_valid++;
      end
      if (error_strobe) begin
        got_kind.push_back(2);
        got_val.push_back(-1);
      end
      if (signal_lost && !last_lost && lost_edge < 0) lost_edge = e;
      last_lost = signal_lost;
      if (e < stim.size()) pwm_in = stim[e];
    end
  endtask

  initial begin
    int k;
    int v;
    int pc;
    bit first;

    tbl[0]  = '{1500, 1'b1, 1'b0, 500};
    tbl[1]  = '{900,  1'b1, 1'b0, 0};
    tbl[2]  = '{2100, 1'b1, 1'b0, 1000};
    tbl[3]  = '{850,  1'b0, 1'b1, 0};
    tbl[4]  = '{899,  1'b0, 1'b1, 0};
    tbl[5]  = '{1000, 1'b1, 1'b0, 0};
    tbl[6]  = '{2000, 1'b1, 1'b0, 1000};
    tbl[7]  = '{2001, 1'b1, 1'b0, 1000};
    tbl[8]  = '{999,  1'b1, 1'b0, 0};
    tbl[9]  = '{1234, 1'b1, 1'b0, 234};
    tbl[10] = '{2101, 1'b0, 1'b1, 0};
    tbl[11] = '{2200, 1'b0, 1'b1, 0};
    tbl[12] = '{1500, 1'b1, 1'b0, 500};
    tbl[13] = '{1,    1'b0, 1'b1, 0};

    stim.delete();
    add(1'b0, 20);
    for (int i = 0; i < NT; i++) begin
      add(1'b1, tbl[i].width);
      add(1'b0, 150);
    end
    add(1'b0, 10);
    run_scenario();
    chk("tbl_events", got_kind.size(), NT);
    first = 1'b1;
    pc    = 0;
    for (int i = 0; i < NT; i++) begin
      k = (i < got_kind.size()) ? got_kind[i] : 0;
      chk($sformatf("tbl%0d_kind", i), k, tbl[i].exp_valid ? 1 : 2);
      if (tbl[i].exp_valid) begin
`ifdef PWM_READER_AVG_EN
        v = first ? tbl[i].exp_clamp : (tbl[i].exp_clamp + pc) / 2;
`else
        v = tbl[i].exp_clamp;
`endif
        pc    = tbl[i].exp_clamp;
        first = 1'b0;
        chk($sformatf("tbl%0d_value", i),
            (i < got_val.size()) ? got_val[i] : -2, v);
      end
    end
    chk("tbl_lost_end", signal_lost, 1'b0);

    stim.delete();
    add(1'b0, 10);
    repeat (12) begin
      add(1'b1, $urandom_range(2300, 800));
      add(1'b0, $urandom_range(600, 1));
    end
    add(1'b0, 10);
    run_scenario();
    chk("rand_events", got_kind.size(), 12);

    stim.delete();
    add(1'b0, 20);
    add(1'b1, 1700);
    add(1'b0, 25100);
    run_scenario();
    chk("tmo_value_before", (got_val.size() > 0) ? got_val[0] : -2,
        700);
    chk("tmo_edge", lost_edge, 20 + 3 + TMO);
    chk("tmo_value_after", value, 0);
    chk("tmo_lost", signal_lost, 1'b1);

    stim.delete();
    add(1'b0, 20);
    add(1'b1, 800);
    run_scenario();
    chk("rstA_events", got_kind.size(), 0);
    stim.delete();
    add(1'b1, 300);
    add(1'b0, 50);
    add(1'b1, 1500);
    add(1'b0, 20);
    run_scenario();
    chk("rstB_valids", n_valid, 1);
    chk("rstB_events", got_kind.size(), 1);
    chk("rstB_value", (got_val.size() > 0) ? got_val[0] : -2, 500);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
